// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared types, default widths and port-slicing helper for the register file
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    localparam int RF_DATA_W  = 32;
    localparam int RF_ADDR_W  = 5;
    localparam int RF_N_READ  = 2;

    // Widest packed port bus and widest single field rd_sel can handle
    localparam int RF_MAX_BUS = 256;
    localparam int RF_MAX_W   = 64;

    // Extract field 'port' of 'width' bits from a packed multi-port bus
    function automatic logic [RF_MAX_W-1:0] rd_sel(input logic [RF_MAX_BUS-1:0] bus,
                                                   input int port,
                                                   input int width);
        logic [RF_MAX_BUS-1:0] sh;
        logic [RF_MAX_W-1:0]   mask;
        sh   = bus >> (port * width);
        mask = (width >= RF_MAX_W) ? '1 : ((RF_MAX_W'(1) << width) - RF_MAX_W'(1));
        return sh[RF_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending bits with claim-over-write priority and N_READ lookups
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int N_READ = RF_N_READ
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    input  logic [N_READ*ADDR_W-1:0] lk_addr,
    output logic [N_READ-1:0]        lk_pend
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] pend_q;

    // Clear on write, set on claim; the set is last so a new producer wins a same-address collision
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            if (clr_en) pend_q[clr_addr] <= 1'b0;
            if (set_en) pend_q[set_addr] <= 1'b1;
        end
    end

    // Raw pending lookup per read port; masking for zero reg / bypass is done by the caller
    always_comb begin
        lk_pend = '0;
        for (int p = 0; p < N_READ; p++) begin
            lk_pend[p] = pend_q[ADDR_W'(rd_sel(RF_MAX_BUS'(lk_addr), p, ADDR_W))];
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with bypass, zero reg, clear sequencer and scoreboard
module regfile_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_READ   = RF_N_READ,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_READ*ADDR_W-1:0] rd_addr,
    output logic [N_READ*DATA_W-1:0] rd_data,
    output logic [N_READ-1:0]        rd_pending,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     init_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               busy;
    logic               wr_ok;
    logic               claim_ok;
    logic [N_READ-1:0]  sb_pend;

    // Clear sequencer state and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Walk every address once, then hand the file over to the pipeline
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == RF_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = RF_READY;
        end
    end

    // Writes and claims are dropped while clearing and, with a zero reg, at address 0
    always_comb begin
        busy     = rst || (state_q == RF_CLEAR);
        wr_ok    = wr_en && !busy && !(ZERO_REG != 0 && wr_addr == '0);
        claim_ok = claim_en && !busy && !(ZERO_REG != 0 && claim_addr == '0);
    end

    assign init_busy = busy;

    // Data array: sequencer zeroing has priority, otherwise normal writeback
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == RF_CLEAR) mem[clr_cnt_q] <= '0;
            else if (wr_ok)          mem[wr_addr]   <= wr_data;
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .N_READ (N_READ)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (claim_ok),
        .set_addr (claim_addr),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr),
        .lk_addr  (rd_addr),
        .lk_pend  (sb_pend)
    );

    // Per-port read: zero reg, then same-cycle writeback bypass, then stored value and pending bit
    always_comb begin
        logic [ADDR_W-1:0] a;
        rd_data    = '0;
        rd_pending = '0;
        for (int p = 0; p < N_READ; p++) begin
            a = ADDR_W'(rd_sel(RF_MAX_BUS'(rd_addr), p, ADDR_W));
            if (!busy && !(ZERO_REG != 0 && a == '0)) begin
                if (wr_en && wr_addr == a) begin
                    rd_data[p*DATA_W +: DATA_W] = wr_data;
                end else begin
                    rd_data[p*DATA_W +: DATA_W] = mem[a];
                    rd_pending[p]               = sb_pend[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - vector table, hand sequences and random run against a reference model
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_pending;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              claim_en;
    logic [AW-1:0]     claim_addr;
    logic              init_busy;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .N_READ(NR), .ZERO_REG(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_pending (rd_pending),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .init_busy  (init_busy)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_pend [DEPTH];
    int            m_busy = DEPTH;

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          ce;
        logic [AW-1:0] ca;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [1:0]    pd;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic ce, input logic [AW-1:0] ca, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rst        = r;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        claim_en   = ce;
        claim_addr = ca;
        rd_addr    = {a1, a0};
    endtask

    function automatic logic [DW-1:0] m_data(input logic [AW-1:0] a);
        if (rst || m_busy > 0 || a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic m_pd(input logic [AW-1:0] a);
        if (rst || m_busy > 0 || a == 0) return 1'b0;
        if (wr_en && wr_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_check();
        logic [AW-1:0] a;
        for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            chk("rd_data", rd_data[p*DW +: DW], m_data(a));
            chk("rd_pending", rd_pending[p], m_pd(a));
        end
        chk("init_busy", init_busy, (rst || m_busy > 0));
    endtask

    task automatic model_update();
        if (rst) begin
            m_busy = DEPTH;
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
        end
    endtask

    task automatic clock_step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Release reset and count busy cycles; a write is attempted at clear step wr_at
    task automatic run_init(input int wr_at, input logic [AW-1:0] wa, output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == wr_at) set_in(0, 1, wa, 32'hFFFF_0000 + 32'(wa), 1, wa, wa, 0);
            else            set_in(0, 0, 0, 0, 0, 0, wa, 0);
            #1;
            model_check();
            if (!init_busy) break;
            n++;
            clock_step();
        end
    endtask

    initial begin
        int n;
        logic [AW-1:0] ra, ca, a0, a1;

        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00};
        vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd5,  5'd3,  32'hDEADBEEF, 32'h0,        2'b00};
        vt[2]  = '{1'b1, 5'd0,  32'h1234,     1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00};
        vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd0,  5'd7,  32'h0,        32'h0,        2'b00};
        vt[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd7,  32'h0,        32'h0,        2'b11};
        vt[5]  = '{1'b1, 5'd7,  32'h55,       1'b0, 5'd0,  5'd7,  5'd0,  32'h55,       32'h0,        2'b00};
        vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  5'd0,  32'h55,       32'h0,        2'b00};
        vt[7]  = '{1'b1, 5'd9,  32'hA5A5A5A5, 1'b1, 5'd9,  5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};
        vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd9,  5'd9,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b11};
        vt[9]  = '{1'b1, 5'd9,  32'h1,        1'b0, 5'd0,  5'd9,  5'd0,  32'h1,        32'h0,        2'b00};
        vt[10] = '{1'b1, 5'd10, 32'h11,       1'b1, 5'd11, 5'd10, 5'd11, 32'h11,       32'h0,        2'b00};
        vt[11] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd10, 5'd11, 32'h11,       32'h0,        2'b10};

        // Reset held one cycle: outputs forced quiet
        set_in(1, 0, 0, 0, 0, 0, 5, 0);
        #1;
        model_check();
        clock_step();

        // Clear sequence after reset, with a write to r3 dropped mid-clear
        run_init(3, 5'd3, n);
        chk("busy_cycles", n, 32);

        // Every register reads zero and nothing is pending
        for (int a = 0; a < 16; a++) begin
            set_in(0, 0, 0, 0, 0, 0, 5'(a), 5'(31 - a));
            #1;
            chk("init_zero0", rd_data[DW-1:0], 0);
            chk("init_zero1", rd_data[2*DW-1:DW], 0);
            chk("init_pend", rd_pending, 0);
            clock_step();
        end

        // Directed vectors: write/read, bypass, zero reg, scoreboard, collision
        for (int i = 0; i < 12; i++) begin
            set_in(0, vt[i].we, vt[i].wa, vt[i].wd, vt[i].ce, vt[i].ca, vt[i].a0, vt[i].a1);
            #1;
            chk($sformatf("vec%0d_d0", i), rd_data[DW-1:0], vt[i].d0);
            chk($sformatf("vec%0d_d1", i), rd_data[2*DW-1:DW], vt[i].d1);
            chk($sformatf("vec%0d_pend", i), rd_pending, vt[i].pd);
            chk($sformatf("vec%0d_busy", i), init_busy, 0);
            clock_step();
        end

        // Reset mid-clear at count 10 restarts the full sequence
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        model_check();
        clock_step();
        for (int i = 0; i < 10; i++) begin
            set_in(0, (i == 4), 5'd5, 32'h77, 0, 0, 5, 0);
            #1;
            model_check();
            clock_step();
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("midclr_rst_busy", init_busy, 1);
        clock_step();
        run_init(5, 5'd12, n);
        chk("midclr_busy_cycles", n, 32);
        set_in(0, 0, 0, 0, 0, 0, 5'd12, 5'd5);
        #1;
        chk("midclr_r12", rd_data[DW-1:0], 0);
        chk("midclr_r5", rd_data[2*DW-1:DW], 0);
        clock_step();

        // Randomized traffic with clustered addresses and rare resets
        for (int i = 0; i < 3000; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            ca = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            a0 = ($urandom_range(0, 2) == 0) ? ra : 5'($urandom_range(0, 3));
            a1 = ($urandom_range(0, 2) == 0) ? ca : 5'($urandom_range(0, 31));
            set_in(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), ra, $urandom,
                   1'($urandom_range(0, 1)), ca, a0, a1);
            #1;
            model_check();
            clock_step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
